// File: rtl/hex_ch_pkg.sv
// Shared constants, 5x7 hex-digit font and pixel lookup helper for the text overlay.
package hex_ch_pkg;

    localparam int CH_COLS    = 8;
    localparam int CH_ROWS    = 8;
    localparam int GLYPH_W    = 5;
    localparam int GLYPH_H    = 7;
    localparam int NUM_GLYPHS = 16;
    localparam int COL_W      = $clog2(CH_COLS);

    // Indexed [glyph][row]; bit 4 of each row is the leftmost column.
    localparam logic [GLYPH_W-1:0] FONT [NUM_GLYPHS][GLYPH_H] = '{
        '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
        '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},
        '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11},
        '{5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E},
        '{5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E},
        '{5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C},
        '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F},
        '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10}
    };

    // Spacing column/row outside the 5x7 glyph area is always background.
    function automatic logic glyph_pixel(input logic [3:0]       ch,
                                         input logic [2:0]       row,
                                         input logic [COL_W-1:0] col);
        logic [GLYPH_W-1:0] rowBits;
        logic               px;
        px      = 1'b0;
        rowBits = '0;
        if (int'(row) < GLYPH_H && int'(col) < GLYPH_W) begin
            rowBits = FONT[ch][row];
            px      = rowBits[COL_W'(GLYPH_W-1) - col];
        end
        return px;
    endfunction

endpackage

// File: rtl/hex_font_rom.sv
// Combinational font lookup: (character, row, column) -> pixel, blank when out of range.
module hex_font_rom
    import hex_ch_pkg::*;
#(
    parameter int CH_W     = 4,
    parameter int CH_ROW_W = 3
) (
    input  logic [CH_W-1:0]     i_ch,
    input  logic [CH_ROW_W-1:0] i_row,
    input  logic [COL_W-1:0]    i_col,
    output logic                o_px
);

    always_comb begin
        o_px = 1'b0;
        if (int'(i_ch) < NUM_GLYPHS && int'(i_row) < CH_ROWS) begin
            o_px = glyph_pixel(4'(i_ch), 3'(i_row), i_col);
        end
    end

endmodule

// File: rtl/hex_ch.sv
// Hex-digit glyph pixel streamer: one registered pixel per read cycle, left to right
// along the selected row; each burst restarts at column 0.
module hex_ch
    import hex_ch_pkg::*;
#(
    parameter int CH_W     = 4,
    parameter int CH_ROW_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_W-1:0]     ch_sel,
    input  logic [CH_ROW_W-1:0] row_sel,
    input  logic                ch_px_rd,
    output logic                ch_px_valid,
    output logic                ch_px_out
);

    logic [COL_W-1:0] r_col;
    logic             r_valid;
    logic             r_px;
    logic             w_px;

    hex_font_rom #(
        .CH_W     (CH_W),
        .CH_ROW_W (CH_ROW_W)
    ) u_rom (
        .i_ch  (ch_sel),
        .i_row (row_sel),
        .i_col (r_col),
        .o_px  (w_px)
    );

    // An idle cycle clears the column so the next burst starts at the left edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_valid <= 1'b0;
            r_px    <= 1'b0;
        end else if (ch_px_rd) begin
            r_col   <= r_col + 1'b1;
            r_valid <= 1'b1;
            r_px    <= w_px;
        end else begin
            r_col   <= '0;
            r_valid <= 1'b0;
            r_px    <= 1'b0;
        end
    end

    assign ch_px_valid = r_valid;
    assign ch_px_out   = r_px;

endmodule

// File: tb/tb_hex_ch.sv
// Scoreboard bench for hex_ch: the driver queues the expected output per cycle and a
// monitor compares it one clock later.
module tb_hex_ch;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] chSel  = '0;
    logic [2:0] rowSel = '0;
    logic       pxRd   = 1'b0;
    logic       pxValid;
    logic       pxOut;

    hex_ch #(.CH_W(4), .CH_ROW_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_sel      (chSel),
        .row_sel     (rowSel),
        .ch_px_rd    (pxRd),
        .ch_px_valid (pxValid),
        .ch_px_out   (pxOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  v;
        logic  p;
        string tag;
    } exp_t;

    exp_t expQ[$];
    exp_t monEntry;
    int   compared   = 0;
    int   mismatched = 0;
    int   modelCol   = 0;

    byte unsigned font [16][7] = '{
        '{8'h0E, 8'h11, 8'h13, 8'h15, 8'h19, 8'h11, 8'h0E},
        '{8'h04, 8'h0C, 8'h04, 8'h04, 8'h04, 8'h04, 8'h0E},
        '{8'h0E, 8'h11, 8'h01, 8'h02, 8'h04, 8'h08, 8'h1F},
        '{8'h1F, 8'h02, 8'h04, 8'h02, 8'h01, 8'h11, 8'h0E},
        '{8'h02, 8'h06, 8'h0A, 8'h12, 8'h1F, 8'h02, 8'h02},
        '{8'h1F, 8'h10, 8'h1E, 8'h01, 8'h01, 8'h11, 8'h0E},
        '{8'h06, 8'h08, 8'h10, 8'h1E, 8'h11, 8'h11, 8'h0E},
        '{8'h1F, 8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h08},
        '{8'h0E, 8'h11, 8'h11, 8'h0E, 8'h11, 8'h11, 8'h0E},
        '{8'h0E, 8'h11, 8'h11, 8'h0F, 8'h01, 8'h02, 8'h0C},
        '{8'h0E, 8'h11, 8'h11, 8'h11, 8'h1F, 8'h11, 8'h11},
        '{8'h1E, 8'h11, 8'h11, 8'h1E, 8'h11, 8'h11, 8'h1E},
        '{8'h0E, 8'h11, 8'h10, 8'h10, 8'h10, 8'h11, 8'h0E},
        '{8'h1C, 8'h12, 8'h11, 8'h11, 8'h11, 8'h12, 8'h1C},
        '{8'h1F, 8'h10, 8'h10, 8'h1E, 8'h10, 8'h10, 8'h1F},
        '{8'h1F, 8'h10, 8'h10, 8'h1E, 8'h10, 8'h10, 8'h10}
    };

    function automatic logic modelPx(input int ch, input int row, input int col);
        byte unsigned b;
        if (row > 6 || col > 4) return 1'b0;
        b = font[ch][row];
        return b[4-col];
    endfunction

    task automatic checkOutput(input string tag, input logic ev, input logic ep);
        compared++;
        if (pxValid !== ev || pxOut !== ep) begin
            mismatched++;
            $display("[TB] FAIL %s: got valid=%b px=%b, expected valid=%b px=%b",
                     tag, pxValid, pxOut, ev, ep);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must show.
    task automatic applyStimulus(input logic r, input logic rd, input logic [3:0] ch,
                                 input logic [2:0] row, input logic ev, input logic ep,
                                 input string tag);
        @(negedge clk);
        rst    = r;
        pxRd   = rd;
        chSel  = ch;
        rowSel = row;
        expQ.push_back('{v: ev, p: ep, tag: tag});
    endtask

    task automatic modelRead(input logic rd, input logic [3:0] ch, input logic [2:0] row,
                             input string tag);
        logic ep;
        ep       = rd ? modelPx(int'(ch), int'(row), modelCol) : 1'b0;
        modelCol = rd ? (modelCol + 1) % 8 : 0;
        applyStimulus(1'b0, rd, ch, row, rd, ep, tag);
    endtask

    // Monitor: one queued expectation per clock, sampled just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            checkOutput(monEntry.tag, monEntry.v, monEntry.p);
        end
    end

    logic t2Exp [8]  = '{0, 1, 1, 1, 0, 0, 0, 0};
    logic t3Exp [16] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    logic t5Exp [9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic t6Exp [8]  = '{1, 0, 0, 1, 1, 0, 0, 0};

    initial begin
        #2;
        checkOutput("t1_init", 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, "t1_rst");
        applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, "t1_release");

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 4'hA, 3'd0, 1'b1, t2Exp[i], "t2_A_row0");
        applyStimulus(1'b0, 1'b0, 4'hA, 3'd0, 1'b0, 1'b0, "t2_idle");

        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 1'b1, (i < 7) ? 4'hA : 4'h7, 3'd0, 1'b1, t3Exp[i], "t3_switch");
        applyStimulus(1'b0, 1'b0, 4'h7, 3'd0, 1'b0, 1'b0, "t3_idle");

        modelCol = 0;
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 8; r++) begin
                for (int k = 0; k < 8; k++) modelRead(1'b1, 4'(c), 3'(r), $sformatf("t4_ch%0h_r%0d_c%0d", c, r, k));
                modelRead(1'b0, 4'(c), 3'(r), "t4_idle");
            end
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'h2, 3'd3, 1'b1, t5Exp[i], "t5_first");
        applyStimulus(1'b0, 1'b0, 4'h2, 3'd3, 1'b0, 1'b0, "t5_gap");
        for (int i = 4; i < 9; i++) applyStimulus(1'b0, 1'b1, 4'h2, 3'd3, 1'b1, t5Exp[i-4], "t5_restart");
        applyStimulus(1'b0, 1'b0, 4'h2, 3'd3, 1'b0, 1'b0, "t5_idle");

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'h0, 3'd2, 1'b1, t6Exp[i], "t6_pre");
        @(negedge clk);
        expQ.push_back('{v: 1'b0, p: 1'b0, tag: "t6_rst_edge"});
        #2 rst = 1'b1;
        #1 checkOutput("t6_async", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 4'h0, 3'd2, 1'b0, 1'b0, "t6_hold");
        applyStimulus(1'b0, 1'b0, 4'h0, 3'd2, 1'b0, 1'b0, "t6_release");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 4'h0, 3'd2, 1'b1, t6Exp[i], "t6_after");
        applyStimulus(1'b0, 1'b0, 4'h0, 3'd2, 1'b0, 1'b0, "t6_idle");

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
